// File: rtl/msrv_32_iadder_scheduler.sv
// -----------------------------------------------------------------------------
// msrv_32_iadder_scheduler
// Shares the single immediate adder between the control-flow unit (pc+imm)
// and the load/store unit (rs1+imm). Arbitrates round-robin and registers the
// chosen operands into the adder inputs. Captures the sum one cycle later and
// returns it on a valid/ready response channel tagged with the requester id.
//
// Ports
//   clk_in, rst_in            clock, asynchronous active-high reset
//   req_valid_in[1:0]         bit0 control-flow, bit1 LSU request
//   req_ready_out[1:0]        one-hot grant (combinational)
//   ctl_pc_in, ctl_imm_in     control-flow operands
//   lsu_rs_1_in, lsu_imm_in   LSU operands
//   rs_1_out, pc_out, imm_out, iadder_src_out   registered adder inputs
//   iadder_in                 adder result
//   resp_valid_out, resp_ready_in, resp_id_out, resp_addr_out,
//   resp_misaligned_out       response channel
// -----------------------------------------------------------------------------
module msrv_32_iadder_scheduler #(
    parameter int unsigned WIDTH       = 32,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [1:0]       req_valid_in,
    output logic [1:0]       req_ready_out,
    input  logic [WIDTH-1:0] ctl_pc_in,
    input  logic [WIDTH-1:0] ctl_imm_in,
    input  logic [WIDTH-1:0] lsu_rs_1_in,
    input  logic [WIDTH-1:0] lsu_imm_in,
    output logic [WIDTH-1:0] rs_1_out,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] imm_out,
    output logic             iadder_src_out,
    input  logic [WIDTH-1:0] iadder_in,
    output logic             resp_valid_out,
    input  logic             resp_ready_in,
    output logic             resp_id_out,
    output logic [WIDTH-1:0] resp_addr_out,
    output logic             resp_misaligned_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state,  w_state_nxt;
    logic             r_last_grant, w_last_grant_nxt;
    logic             r_id,     w_id_nxt;
    logic [WIDTH-1:0] r_rs_1,   w_rs_1_nxt;
    logic [WIDTH-1:0] r_pc,     w_pc_nxt;
    logic [WIDTH-1:0] r_imm,    w_imm_nxt;
    logic             r_src,    w_src_nxt;
    logic             r_resp_valid, w_resp_valid_nxt;
    logic             r_resp_id,    w_resp_id_nxt;
    logic [WIDTH-1:0] r_resp_addr,  w_resp_addr_nxt;
    logic             r_resp_mis,   w_resp_mis_nxt;

    logic             w_can_accept;
    logic             w_grant;
    logic [1:0]       w_ready;
    logic             w_accept;

    // Arbitration: a lone requester wins; on contention the one not granted last wins.
    always_comb begin
        w_can_accept = (r_state == IDLE) || ((r_state == RESP) && resp_ready_in);
        w_grant      = (&req_valid_in) ? ~r_last_grant : req_valid_in[1];
        w_ready      = 2'b00;
        if (!rst_in && w_can_accept && (|req_valid_in)) begin
            w_ready = w_grant ? 2'b10 : 2'b01;
        end
        w_accept = |(req_valid_in & w_ready);
    end

    // Next-state and next-register values.
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_id_nxt         = r_id;
        w_rs_1_nxt       = r_rs_1;
        w_pc_nxt         = r_pc;
        w_imm_nxt        = r_imm;
        w_src_nxt        = r_src;
        w_resp_valid_nxt = r_resp_valid;
        w_resp_id_nxt    = r_resp_id;
        w_resp_addr_nxt  = r_resp_addr;
        w_resp_mis_nxt   = r_resp_mis;

        case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = CALC;
            end
            CALC: begin
                // Adder is combinational on the registered operands; take its sum now.
                w_resp_addr_nxt  = iadder_in;
                w_resp_id_nxt    = r_id;
                w_resp_mis_nxt   = ALIGN_CHECK && !r_id && (iadder_in[1:0] != 2'b00);
                w_resp_valid_nxt = 1'b1;
                w_state_nxt      = RESP;
            end
            RESP: begin
                if (resp_ready_in) begin
                    w_resp_valid_nxt = 1'b0;
                    w_state_nxt      = w_accept ? CALC : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Operand load is shared by the IDLE and RESP accept paths.
        if (w_accept) begin
            w_id_nxt         = w_grant;
            w_last_grant_nxt = w_grant;
            if (w_grant) begin
                w_rs_1_nxt = lsu_rs_1_in;
                w_pc_nxt   = '0;
                w_imm_nxt  = lsu_imm_in;
                w_src_nxt  = 1'b1;
            end else begin
                w_rs_1_nxt = '0;
                w_pc_nxt   = ctl_pc_in;
                w_imm_nxt  = ctl_imm_in;
                w_src_nxt  = 1'b0;
            end
        end
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_rs_1       <= '0;
            r_pc         <= '0;
            r_imm        <= '0;
            r_src        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_addr  <= '0;
            r_resp_mis   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_id         <= w_id_nxt;
            r_rs_1       <= w_rs_1_nxt;
            r_pc         <= w_pc_nxt;
            r_imm        <= w_imm_nxt;
            r_src        <= w_src_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_id    <= w_resp_id_nxt;
            r_resp_addr  <= w_resp_addr_nxt;
            r_resp_mis   <= w_resp_mis_nxt;
        end
    end

    assign req_ready_out       = w_ready;
    assign rs_1_out            = r_rs_1;
    assign pc_out              = r_pc;
    assign imm_out             = r_imm;
    assign iadder_src_out      = r_src;
    assign resp_valid_out      = r_resp_valid;
    assign resp_id_out         = r_resp_id;
    assign resp_addr_out       = r_resp_addr;
    assign resp_misaligned_out = r_resp_mis;

endmodule

// File: tb/tb_msrv_32_iadder_scheduler.sv
// -----------------------------------------------------------------------------
// tb_msrv_32_iadder_scheduler
// Directed bench for the adder scheduler. A second instance with ALIGN_CHECK=0
// sees identical stimulus. The external adder is modelled in the bench.
// -----------------------------------------------------------------------------
module tb_msrv_32_iadder_scheduler;

    logic        clk_in;
    logic        rst_in;
    logic [1:0]  req_valid_in;
    logic [31:0] ctl_pc_in, ctl_imm_in, lsu_rs_1_in, lsu_imm_in;
    logic        resp_ready_in;

    logic [1:0]  req_ready_out, req_ready_out2;
    logic [31:0] rs_1_out, pc_out, imm_out, rs_1_out2, pc_out2, imm_out2;
    logic        iadder_src_out, iadder_src_out2;
    logic [31:0] iadder_in, iadder_in2;
    logic        resp_valid_out, resp_valid_out2;
    logic        resp_id_out, resp_id_out2;
    logic [31:0] resp_addr_out, resp_addr_out2;
    logic        resp_misaligned_out, resp_misaligned_out2;

    int n_tests = 0;
    int n_fail  = 0;

    // Immediate adder model.
    assign iadder_in  = (iadder_src_out  ? rs_1_out  : pc_out)  + imm_out;
    assign iadder_in2 = (iadder_src_out2 ? rs_1_out2 : pc_out2) + imm_out2;

    msrv_32_iadder_scheduler #(.WIDTH(32), .ALIGN_CHECK(1'b1)) u_dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .ctl_pc_in(ctl_pc_in), .ctl_imm_in(ctl_imm_in),
        .lsu_rs_1_in(lsu_rs_1_in), .lsu_imm_in(lsu_imm_in),
        .rs_1_out(rs_1_out), .pc_out(pc_out), .imm_out(imm_out),
        .iadder_src_out(iadder_src_out), .iadder_in(iadder_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .resp_id_out(resp_id_out), .resp_addr_out(resp_addr_out),
        .resp_misaligned_out(resp_misaligned_out)
    );

    msrv_32_iadder_scheduler #(.WIDTH(32), .ALIGN_CHECK(1'b0)) u_dut_noalign (
        .clk_in(clk_in), .rst_in(rst_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out2),
        .ctl_pc_in(ctl_pc_in), .ctl_imm_in(ctl_imm_in),
        .lsu_rs_1_in(lsu_rs_1_in), .lsu_imm_in(lsu_imm_in),
        .rs_1_out(rs_1_out2), .pc_out(pc_out2), .imm_out(imm_out2),
        .iadder_src_out(iadder_src_out2), .iadder_in(iadder_in2),
        .resp_valid_out(resp_valid_out2), .resp_ready_in(resp_ready_in),
        .resp_id_out(resp_id_out2), .resp_addr_out(resp_addr_out2),
        .resp_misaligned_out(resp_misaligned_out2)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // One isolated request through IDLE -> CALC -> RESP -> IDLE with resp_ready=1.
    task automatic run_req(input string tag, input logic [1:0] v,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_addr, input logic exp_mis);
        logic lsu;
        lsu = v[1];
        resp_ready_in = 1'b1;
        req_valid_in  = v;
        if (lsu) begin lsu_rs_1_in = a; lsu_imm_in = b; end
        else     begin ctl_pc_in   = a; ctl_imm_in = b; end
        #1;
        check({tag, " ready"}, 32'(req_ready_out), 32'(v));
        tick();
        // Scramble operands: only the grant cycle must hold them.
        req_valid_in = 2'b00;
        ctl_pc_in = 32'hDEAD_0001; ctl_imm_in = 32'hDEAD_0002;
        lsu_rs_1_in = 32'hDEAD_0003; lsu_imm_in = 32'hDEAD_0004;
        check({tag, " src"}, 32'(iadder_src_out), 32'(lsu));
        check({tag, " idle_opnd"}, lsu ? pc_out : rs_1_out, 32'h0);
        check({tag, " calc_valid"}, 32'(resp_valid_out), 32'h0);
        tick();
        check({tag, " valid"}, 32'(resp_valid_out), 32'h1);
        check({tag, " id"}, 32'(resp_id_out), 32'(lsu));
        check({tag, " addr"}, resp_addr_out, exp_addr);
        check({tag, " mis"}, 32'(resp_misaligned_out), 32'(exp_mis));
        check({tag, " mis_noalign"}, 32'(resp_misaligned_out2), 32'h0);
        tick();
        check({tag, " drop"}, 32'(resp_valid_out), 32'h0);
        check({tag, " hold"}, resp_addr_out, exp_addr);
    endtask

    initial begin
        rst_in = 1'b1;
        req_valid_in = 2'b01;
        resp_ready_in = 1'b0;
        ctl_pc_in = '0; ctl_imm_in = '0; lsu_rs_1_in = '0; lsu_imm_in = '0;
        tick(); tick();
        check("rst ready", 32'(req_ready_out), 32'h0);
        check("rst valid", 32'(resp_valid_out), 32'h0);
        check("rst pc", pc_out, 32'h0);
        check("rst addr", resp_addr_out, 32'h0);
        rst_in = 1'b0;
        req_valid_in = 2'b00;
        tick();

        // Round-robin alternation: ctl 0x100+4, LSU 0x200+8.
        resp_ready_in = 1'b1;
        ctl_pc_in = 32'h100; ctl_imm_in = 32'h4;
        lsu_rs_1_in = 32'h200; lsu_imm_in = 32'h8;
        req_valid_in = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr grant", 32'(req_ready_out), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) begin
                check("rr valid", 32'(resp_valid_out), 32'h1);
                check("rr id", 32'(resp_id_out), ((k - 1) % 2 == 0) ? 32'h0 : 32'h1);
                check("rr addr", resp_addr_out, ((k - 1) % 2 == 0) ? 32'h104 : 32'h208);
            end
            tick();
            check("rr calc ready", 32'(req_ready_out), 32'h0);
            check("rr calc valid", 32'(resp_valid_out), 32'h0);
            tick();
        end
        req_valid_in = 2'b00;
        check("rr last valid", 32'(resp_valid_out), 32'h1);
        check("rr last id", 32'(resp_id_out), 32'h1);
        check("rr last addr", resp_addr_out, 32'h208);
        tick();

        run_req("ctl", 2'b01, 32'h0001_0000, 32'h1234_5678, 32'h1235_5678, 1'b0);
        run_req("lsu", 2'b10, 32'hAABB_CCDD, 32'h1234_5678, 32'hBCF0_2355, 1'b0);
        run_req("ctl_mis", 2'b01, 32'h0002_0000, 32'h8765_4321, 32'h8767_4321, 1'b1);
        run_req("lsu_wrap", 2'b10, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0000_0004, 1'b0);

        // Backpressure: ctl result held while LSU waits.
        resp_ready_in = 1'b0;
        req_valid_in = 2'b01;
        ctl_pc_in = 32'h3000; ctl_imm_in = 32'h10;
        tick();
        req_valid_in = 2'b10;
        lsu_rs_1_in = 32'h1000; lsu_imm_in = 32'h20;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp valid", 32'(resp_valid_out), 32'h1);
            check("bp addr", resp_addr_out, 32'h3010);
            check("bp id", 32'(resp_id_out), 32'h0);
            check("bp ready", 32'(req_ready_out), 32'h0);
            tick();
        end
        resp_ready_in = 1'b1;
        #1;
        check("bp accept", 32'(req_ready_out), 32'h2);
        tick();
        req_valid_in = 2'b00;
        check("bp calc valid", 32'(resp_valid_out), 32'h0);
        check("bp calc src", 32'(iadder_src_out), 32'h1);
        tick();
        check("bp2 valid", 32'(resp_valid_out), 32'h1);
        check("bp2 id", 32'(resp_id_out), 32'h1);
        check("bp2 addr", resp_addr_out, 32'h1020);
        tick();

        // Reset during CALC discards the in-flight result.
        req_valid_in = 2'b01;
        ctl_pc_in = 32'h40; ctl_imm_in = 32'h1;
        tick();
        req_valid_in = 2'b00;
        check("mid pre pc", pc_out, 32'h40);
        rst_in = 1'b1;
        #1;
        check("mid rst pc", pc_out, 32'h0);
        check("mid rst imm", imm_out, 32'h0);
        check("mid rst valid", 32'(resp_valid_out), 32'h0);
        check("mid rst addr", resp_addr_out, 32'h0);
        tick();
        rst_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post rst valid", 32'(resp_valid_out), 32'h0);
        end
        run_req("post_rst", 2'b10, 32'h10, 32'h4, 32'h14, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/msrv_32_iadder_scheduler.md
Name: msrv_32_iadder_scheduler

Overview:
Sequences and shares the single immediate adder (msrv_32_immediate_adder) between two requesters: the control-flow unit (PC-relative branch/JAL targets) and the load/store unit (rs1+imm effective addresses). It arbitrates round-robin and registers the selected operands into the adder's rs_1/pc/imm/iadder_src inputs. It captures the adder result and returns it over a valid/ready response channel tagged with the requester ID. It sits between decode/issue and the adder, and is the only driver of the adder inputs.

Parameters:
WIDTH, 32, datapath width of operands and result
ALIGN_CHECK, 1, 1 = flag control-flow targets with addr[1:0] != 0; 0 = flag never set

Ports:
clk_in  input  1  core clock, all state on rising edge
rst_in  input  1  asynchronous, active-high reset
req_valid_in  input  2  bit0 = control-flow request, bit1 = LSU request
req_ready_out  output  2  one-hot grant/accept, combinational
ctl_pc_in  input  WIDTH  control-flow PC operand
ctl_imm_in  input  WIDTH  control-flow immediate
lsu_rs_1_in  input  WIDTH  LSU base register value
lsu_imm_in  input  WIDTH  LSU immediate
rs_1_out  output  WIDTH  to adder rs_1_in (registered)
pc_out  output  WIDTH  to adder pc_in (registered)
imm_out  output  WIDTH  to adder imm_in (registered)
iadder_src_out  output  1  to adder iadder_src_in: 1 = rs_1, 0 = pc (registered)
iadder_in  input  WIDTH  adder result iadder_out
resp_valid_out  output  1  response valid
resp_ready_in  input  1  consumer ready
resp_id_out  output  1  0 = control-flow, 1 = LSU
resp_addr_out  output  WIDTH  captured sum
resp_misaligned_out  output  1  target misalignment flag

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-high (clk_in, rst_in). While rst_in=1, all registered outputs are 0 and the FSM is IDLE; last_grant=1.
- FSM states: IDLE, CALC, RESP.
- can_accept = (state==IDLE) or (state==RESP and resp_ready_in).
- Arbitration, when can_accept:
  - One valid requester: it is granted.
  - Both valid: grant the requester not equal to last_grant.
  - req_ready_out is the one-hot grant. It is 0 in CALC, 0 in RESP without resp_ready_in, and 0 during reset.
- Accept (req_valid_in[g] & req_ready_out[g]): register the operands, set id=g and last_grant=g, next state CALC.
  - g=0: pc_out=ctl_pc_in, imm_out=ctl_imm_in, rs_1_out=0, iadder_src_out=0.
  - g=1: rs_1_out=lsu_rs_1_in, imm_out=lsu_imm_in, pc_out=0, iadder_src_out=1.
- CALC (exactly one cycle): adder is combinational on the registered operands. At the end of CALC, capture:
  - resp_addr_out = iadder_in.
  - resp_misaligned_out = ALIGN_CHECK & (id==0) & (iadder_in[1:0]!=0).
  - Set resp_valid_out=1. Next state RESP.
- RESP: resp_addr_out, resp_id_out and resp_misaligned_out hold stable while resp_valid_out=1 and resp_ready_in=0.
  - On resp_ready_in=1 with an accept in the same cycle: resp_valid_out drops, operands reload, next state CALC.
  - On resp_ready_in=1 without an accept: resp_valid_out=0, next state IDLE.
- Latency: accept in cycle N gives resp_valid_out=1 in cycle N+2. Sustained throughput is one result per 2 cycles.
- Adder outputs hold their last values in IDLE/RESP. resp_* fields hold their last values after the handshake.
- Arithmetic: modulo 2^WIDTH; carry out is discarded, no overflow flag.
- Reset mid-operation (CALC or RESP): the in-flight result is discarded, resp_valid_out goes to 0 immediately, and no response is issued after reset.
- Requests dropped before grant: allowed, with no state effect.
- A requester must hold its operands stable only in the cycle it is granted.

Test Plan:
- Ctl only: pc=0x00010000, imm=0x12345678, resp_ready_in=1 -> accepted cycle N; cycle N+2 resp_valid=1, id=0, addr=0x12355678, misaligned=0; adder sees iadder_src=0.
- LSU only: rs1=0xAABBCCDD, imm=0x12345678 -> iadder_src_out=1, addr=0xBCF02355, id=1, misaligned=0.
- Misalign and wrap:
  - Ctl pc=0x00020000, imm=0x87654321 -> addr=0x87674321, misaligned=1.
  - LSU rs1=0xFFFFFFFC, imm=8 -> addr=0x00000004, misaligned=0.
  - ALIGN_CHECK=0 rerun of the ctl case -> misaligned=0.
- Both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1 starting with 0 after reset; a response every 2 cycles.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_valid/addr/id stable, req_ready_out=00. Raise resp_ready with LSU valid -> same-cycle accept, next response 2 cycles later.
- Reset: assert rst_in during CALC -> all outputs 0 asynchronously; after release no response is issued; the next request completes normally.
